// File: rtl/warmboot_sequencer_if.sv
// Host boot-request handshake plus the SB_WARMBOOT control pins.
`timescale 1ns/1ps
interface warmboot_sequencer_if;
    logic       req_valid;
    logic [1:0] req_image;
    logic       req_ready;
    logic       wb_s1;
    logic       wb_s0;
    logic       wb_boot;

    modport master (output req_valid, req_image,
                    input  req_ready, wb_s1, wb_s0, wb_boot);
    modport slave  (input  req_valid, req_image,
                    output req_ready, wb_s1, wb_s0, wb_boot);
endinterface

// File: rtl/warmboot_sequencer.sv
// Warm-boot controller: picks the next iCE40 image from host request, debounced button
// or timeout, then drives SB_WARMBOOT S1/S0 with a setup window before raising BOOT.
`timescale 1ns/1ps
module warmboot_sequencer #(
    parameter int unsigned LOG2DELAY     = 22,
    parameter int unsigned NUM_LEDS      = 5,
    parameter int unsigned IMAGE_ID      = 0,
    parameter int unsigned AUTO_IMAGE    = 1,
    parameter int unsigned AUTO_BOOT     = 1,
    parameter int unsigned BOOT_TICKS    = 15,
    parameter int unsigned SETUP_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_LOG2 = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    btn,
    warmboot_sequencer_if.slave     bus,
    output logic [NUM_LEDS-1:0]     led
);
    localparam int unsigned PRESC_W = LOG2DELAY;
    localparam int unsigned DEB_W   = DEBOUNCE_LOG2;
    localparam int unsigned TICK_W  = 8;
    localparam int unsigned SETUP_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BOOT} state_e;

    state_e               state_q,     state_d;
    logic [PRESC_W-1:0]   presc_q,     presc_d;
    logic                 tick_q,      tick_d;
    logic [TICK_W-1:0]    tick_cnt_q,  tick_cnt_d;
    logic                 sync1_q,     sync1_d;
    logic                 sync2_q,     sync2_d;
    logic [DEB_W-1:0]     deb_cnt_q,   deb_cnt_d;
    logic                 deb_level_q, deb_level_d;
    logic                 press_q,     press_d;
    logic [SETUP_W-1:0]   setup_cnt_q, setup_cnt_d;
    logic                 req_ready_q, req_ready_d;
    logic                 wb_s1_q,     wb_s1_d;
    logic                 wb_s0_q,     wb_s0_d;
    logic                 wb_boot_q,   wb_boot_d;
    logic [NUM_LEDS-1:0]  led_q,       led_d;

    // Next-state: prescaler, button debounce, trigger arbitration and registered outputs
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q + PRESC_W'(1);
        tick_d      = (presc_q == '1);
        tick_cnt_d  = tick_cnt_q;
        sync1_d     = btn;
        sync2_d     = sync1_q;
        deb_cnt_d   = deb_cnt_q;
        deb_level_d = deb_level_q;
        press_d     = 1'b0;
        setup_cnt_d = setup_cnt_q;
        wb_s1_d     = wb_s1_q;
        wb_s0_d     = wb_s0_q;
        wb_boot_d   = wb_boot_q;
        led_d       = led_q;

        // Level flips only after 2**DEB_W consecutive samples that disagree with it
        if (sync2_q == deb_level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == '1) begin
            deb_cnt_d   = '0;
            deb_level_d = sync2_q;
            press_d     = sync2_q;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                setup_cnt_d = '0;
                if (tick_q && (tick_cnt_q != '1)) begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                end
                if (bus.req_valid && req_ready_q) begin
                    state_d            = S_ARMED;
                    {wb_s1_d, wb_s0_d} = bus.req_image;
                end else if (press_q) begin
                    state_d            = S_ARMED;
                    {wb_s1_d, wb_s0_d} = 2'(AUTO_IMAGE);
                end else if ((AUTO_BOOT != 0) && tick_q &&
                             (tick_cnt_q == TICK_W'(BOOT_TICKS - 1))) begin
                    state_d            = S_ARMED;
                    {wb_s1_d, wb_s0_d} = 2'(AUTO_IMAGE);
                end
            end
            S_ARMED: begin
                if (setup_cnt_q == SETUP_W'(SETUP_CYCLES - 1)) begin
                    state_d   = S_BOOT;
                    wb_boot_d = 1'b1;
                end else begin
                    setup_cnt_d = setup_cnt_q + SETUP_W'(1);
                end
            end
            S_BOOT: begin
                wb_boot_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        led_d[0]    = led_q[0] ^ tick_q;
        for (int unsigned i = 1; i < NUM_LEDS; i++) begin
            led_d[i] = (state_d != S_IDLE) || ((i - 1) == IMAGE_ID);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            tick_cnt_q  <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_cnt_q   <= '0;
            deb_level_q <= 1'b0;
            press_q     <= 1'b0;
            setup_cnt_q <= '0;
            req_ready_q <= 1'b1;
            wb_s1_q     <= 1'b0;
            wb_s0_q     <= 1'b0;
            wb_boot_q   <= 1'b0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            tick_cnt_q  <= tick_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_level_q <= deb_level_d;
            press_q     <= press_d;
            setup_cnt_q <= setup_cnt_d;
            req_ready_q <= req_ready_d;
            wb_s1_q     <= wb_s1_d;
            wb_s0_q     <= wb_s0_d;
            wb_boot_q   <= wb_boot_d;
            led_q       <= led_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.wb_s1     = wb_s1_q;
    assign bus.wb_s0     = wb_s0_q;
    assign bus.wb_boot   = wb_boot_q;
    assign led           = led_q;
endmodule

// File: tb/tb_warmboot_sequencer.sv
// Bench for warmboot_sequencer: event-time reference model, randomized triggers and button noise.
`timescale 1ns/1ps
module tb_warmboot_sequencer;
    localparam int SETUP    = 4;
    localparam int BT       = 3;
    localparam int TICKP    = 16;
    localparam int DEB_N    = 8;
    localparam int AUTO_IMG = 1;
    localparam int IMG_ID   = 0;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic btn = 1'b0;
    logic btn_b = 1'b0;
    logic [4:0] led_a, led_b;
    logic [8:0] obs_a, obs_b;

    warmboot_sequencer_if wif_a ();
    warmboot_sequencer_if wif_b ();

    warmboot_sequencer #(.LOG2DELAY(4), .NUM_LEDS(5), .IMAGE_ID(IMG_ID), .AUTO_IMAGE(AUTO_IMG),
        .AUTO_BOOT(1), .BOOT_TICKS(BT), .SETUP_CYCLES(SETUP), .DEBOUNCE_LOG2(3))
    dut_a (.clk(clk), .resetn(resetn), .btn(btn), .bus(wif_a.slave), .led(led_a));

    warmboot_sequencer #(.LOG2DELAY(4), .NUM_LEDS(5), .IMAGE_ID(IMG_ID), .AUTO_IMAGE(AUTO_IMG),
        .AUTO_BOOT(0), .BOOT_TICKS(BT), .SETUP_CYCLES(SETUP), .DEBOUNCE_LOG2(3))
    dut_b (.clk(clk), .resetn(resetn), .btn(btn_b), .bus(wif_b.slave), .led(led_b));

    always #5 clk = ~clk;

    assign obs_a = {wif_a.req_ready, wif_a.wb_s1, wif_a.wb_s0, wif_a.wb_boot, led_a};
    assign obs_b = {wif_b.req_ready, wif_b.wb_s1, wif_b.wb_s0, wif_b.wb_boot, led_b};

    // Reference model state: edges since reset, trigger cycle/slot, debounced button view
    int         cyc;
    int         trig_cyc;
    logic [1:0] trig_sel;
    bit         d1, d2, m_level, press_vis;
    bit         win[$];
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic bit led0(int k);
        return (k >= 1) ? bit'(((k - 1) / TICKP) % 2) : 1'b0;
    endfunction

    function automatic logic [8:0] exp_a(int k);
        logic [8:0] v;
        bit armed, boot;
        armed  = (trig_cyc >= 0) && (k >= trig_cyc + 1);
        boot   = (trig_cyc >= 0) && (k >= trig_cyc + 1 + SETUP);
        v[8]   = !armed;
        v[7:6] = armed ? trig_sel : 2'b00;
        v[5]   = boot;
        v[4:1] = armed ? 4'hF : ((k >= 1) ? 4'(1 << IMG_ID) : 4'h0);
        v[0]   = led0(k);
        return v;
    endfunction

    function automatic logic [8:0] exp_b(int k);
        return {1'b1, 2'b00, 1'b0, ((k >= 1) ? 4'(1 << IMG_ID) : 4'h0), led0(k)};
    endfunction

    task automatic eval_trigger(int k);
        if (trig_cyc < 0) begin
            if (wif_a.req_valid) begin
                trig_cyc = k; trig_sel = wif_a.req_image;
            end else if (press_vis) begin
                trig_cyc = k; trig_sel = 2'(AUTO_IMG);
            end else if (k > 0 && (k % TICKP) == 0 && (k / TICKP) == BT) begin
                trig_cyc = k; trig_sel = 2'(AUTO_IMG);
            end
        end
    endtask

    task automatic deb_update();
        bit s, all_diff;
        s = d2; d2 = d1; d1 = btn;
        win.push_back(s);
        if (win.size() > DEB_N) void'(win.pop_front());
        press_vis = 1'b0;
        if (win.size() == DEB_N) begin
            all_diff = 1'b1;
            foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                m_level = !m_level;
                press_vis = m_level;
                win.delete();
            end
        end
    endtask

    task automatic advance();
        eval_trigger(cyc);
        @(posedge clk);
        cyc++;
        deb_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0; btn = 1'b0; wif_a.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        cyc = 0; trig_cyc = -1; trig_sel = 2'b00;
        d1 = 0; d2 = 0; m_level = 0; press_vis = 0; win.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (obs_a !== 9'h100) begin n_err++; $display("FAIL reset_a got=%b want=%b", obs_a, 9'h100); end
        n_cmp++;
        if (obs_b !== 9'h100) begin n_err++; $display("FAIL reset_b got=%b want=%b", obs_b, 9'h100); end
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            advance();
            n_cmp++;
            if (obs_a !== exp_a(cyc)) begin n_err++; $display("FAIL reset_run_a cyc=%0d got=%b want=%b", cyc, obs_a, exp_a(cyc)); end
            n_cmp++;
            if (obs_b !== exp_b(cyc)) begin n_err++; $display("FAIL reset_run_b cyc=%0d got=%b want=%b", cyc, obs_b, exp_b(cyc)); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        n_cmp++;
        if (obs_a !== exp_a(0)) begin n_err++; $display("FAIL timeout_c0 got=%b want=%b", obs_a, exp_a(0)); end
        for (int i = 0; i < 70; i++) begin
            advance();
            n_cmp++;
            if (obs_a !== exp_a(cyc)) begin n_err++; $display("FAIL timeout cyc=%0d got=%b want=%b", cyc, obs_a, exp_a(cyc)); end
            if (cyc == 48 || cyc == 49) begin
                n_cmp++;
                if ({wif_a.req_ready, wif_a.wb_s1, wif_a.wb_s0} !== ((cyc == 48) ? 3'b100 : 3'b001)) begin
                    n_err++; $display("FAIL timeout_arm cyc=%0d got=%b", cyc, {wif_a.req_ready, wif_a.wb_s1, wif_a.wb_s0});
                end
            end
            if (cyc == 52 || cyc == 53) begin
                n_cmp++;
                if (wif_a.wb_boot !== (cyc == 53)) begin n_err++; $display("FAIL timeout_boot cyc=%0d got=%b", cyc, wif_a.wb_boot); end
            end
        end
    endtask

    task automatic test_host_req();
        do_reset();
        wif_a.req_image = 2'b10;
        for (int i = 0; i < 70; i++) begin
            wif_a.req_valid = (cyc == 5);
            advance();
            n_cmp++;
            if (obs_a !== exp_a(cyc)) begin n_err++; $display("FAIL host_req cyc=%0d got=%b want=%b", cyc, obs_a, exp_a(cyc)); end
            if (cyc == 6) begin
                n_cmp++;
                if ({wif_a.req_ready, wif_a.wb_s1, wif_a.wb_s0} !== 3'b010) begin
                    n_err++; $display("FAIL host_req_sel got=%b want=010", {wif_a.req_ready, wif_a.wb_s1, wif_a.wb_s0});
                end
            end
            if (cyc == 9 || cyc == 10) begin
                n_cmp++;
                if (wif_a.wb_boot !== (cyc == 10)) begin n_err++; $display("FAIL host_req_boot cyc=%0d got=%b", cyc, wif_a.wb_boot); end
            end
        end
        wif_a.req_valid = 1'b0;
    endtask

    task automatic test_btn();
        int hi_left, lo_left, w;
        do_reset();
        hi_left = 0; lo_left = 0;
        for (int i = 0; i < 60; i++) begin
            if (cyc >= 40) btn = 1'b0;
            else if (hi_left > 0) begin btn = 1'b1; hi_left--; end
            else if (lo_left > 0) begin btn = 1'b0; lo_left--; end
            else begin hi_left = $urandom_range(1, 7) - 1; lo_left = $urandom_range(1, 4); btn = 1'b1; end
            advance();
            n_cmp++;
            if (obs_a !== exp_a(cyc)) begin n_err++; $display("FAIL btn_glitch cyc=%0d got=%b want=%b", cyc, obs_a, exp_a(cyc)); end
            if (cyc == 48) begin
                n_cmp++;
                if (wif_a.req_ready !== 1'b1) begin n_err++; $display("FAIL btn_glitch_idle got=%b want=1", wif_a.req_ready); end
            end
        end
        do_reset();
        w = $urandom_range(0, 5);
        for (int i = 0; i < 40; i++) begin
            btn = (cyc >= w) && (cyc < w + 20);
            advance();
            n_cmp++;
            if (obs_a !== exp_a(cyc)) begin n_err++; $display("FAIL btn_hold cyc=%0d got=%b want=%b", cyc, obs_a, exp_a(cyc)); end
            if (cyc == w + 10 || cyc == w + 11) begin
                n_cmp++;
                if ({wif_a.req_ready, wif_a.wb_s1, wif_a.wb_s0} !== ((cyc == w + 10) ? 3'b100 : 3'b001)) begin
                    n_err++; $display("FAIL btn_hold_arm cyc=%0d got=%b", cyc, {wif_a.req_ready, wif_a.wb_s1, wif_a.wb_s0});
                end
            end
        end
        btn = 1'b0;
    endtask

    task automatic test_priority();
        logic [1:0] img1;
        int t_acc;
        do_reset();
        img1 = 2'b10; t_acc = -1;
        for (int i = 0; i < 30; i++) begin
            btn = 1'b1;
            wif_a.req_valid = 1'b0;
            if (press_vis && trig_cyc < 0) begin
                img1 = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
                wif_a.req_valid = 1'b1; wif_a.req_image = img1; t_acc = cyc;
            end else if (t_acc >= 0 && cyc == t_acc + 2) begin
                wif_a.req_valid = 1'b1; wif_a.req_image = img1 ^ 2'b01;
            end
            advance();
            n_cmp++;
            if (obs_a !== exp_a(cyc)) begin n_err++; $display("FAIL priority cyc=%0d got=%b want=%b", cyc, obs_a, exp_a(cyc)); end
        end
        n_cmp++;
        if ({wif_a.wb_s1, wif_a.wb_s0, wif_a.wb_boot} !== {img1, 1'b1}) begin
            n_err++; $display("FAIL priority_final got=%b want=%b", {wif_a.wb_s1, wif_a.wb_s0, wif_a.wb_boot}, {img1, 1'b1});
        end
        btn = 1'b0; wif_a.req_valid = 1'b0;
    endtask

    task automatic test_reset_armed();
        do_reset();
        wif_a.req_image = 2'($urandom_range(0, 3));
        for (int i = 0; i < 5; i++) begin
            wif_a.req_valid = (cyc == 3);
            advance();
            n_cmp++;
            if (obs_a !== exp_a(cyc)) begin n_err++; $display("FAIL rst_armed_pre cyc=%0d got=%b want=%b", cyc, obs_a, exp_a(cyc)); end
        end
        wif_a.req_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (obs_a !== 9'h100) begin n_err++; $display("FAIL rst_armed_async got=%b want=%b", obs_a, 9'h100); end
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 60; i++) begin
            advance();
            n_cmp++;
            if (obs_a !== exp_a(cyc)) begin n_err++; $display("FAIL rst_armed_post cyc=%0d got=%b want=%b", cyc, obs_a, exp_a(cyc)); end
            if (cyc == 53) begin
                n_cmp++;
                if ({wif_a.wb_s1, wif_a.wb_s0, wif_a.wb_boot} !== 3'b011) begin
                    n_err++; $display("FAIL rst_armed_reboot got=%b want=011", {wif_a.wb_s1, wif_a.wb_s0, wif_a.wb_boot});
                end
            end
        end
    endtask

    task automatic test_random();
        int rc;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            rc = $urandom_range(1, 60);
            wif_a.req_image = 2'($urandom_range(0, 3));
            for (int i = 0; i < 70; i++) begin
                wif_a.req_valid = (cyc == rc);
                if ($urandom_range(0, 5) == 0) btn = !btn;
                advance();
                n_cmp++;
                if (obs_a !== exp_a(cyc)) begin n_err++; $display("FAIL random r=%0d cyc=%0d got=%b want=%b", r, cyc, obs_a, exp_a(cyc)); end
            end
        end
        btn = 1'b0; wif_a.req_valid = 1'b0;
    endtask

    task automatic test_no_autoboot();
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            advance();
            n_cmp++;
            if (obs_b !== exp_b(cyc)) begin n_err++; $display("FAIL no_autoboot cyc=%0d got=%b want=%b", cyc, obs_b, exp_b(cyc)); end
        end
    endtask

    initial begin
        wif_a.req_valid = 1'b0; wif_a.req_image = 2'b00;
        wif_b.req_valid = 1'b0; wif_b.req_image = 2'b00;
        @(negedge clk);
        test_reset();
        test_timeout();
        test_host_req();
        test_btn();
        test_priority();
        test_reset_armed();
        test_random();
        test_no_autoboot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
